// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: sequences duty_cycle/enable of a free-running PWM block.
// A target duty and step are accepted over a valid/ready handshake. The duty
// then moves toward the target by one step per PWM period. It only changes on
// the last count of a period, so every period is generated with a single duty.
//
// Optional build macro: FADE_HOLD_EN. It adds the hold_periods input and a
// HOLD state that dwells at the target for hold_periods periods before done.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   run               PWM count request, registered onto pwm_enable
//   tgt_valid/ready   target handshake
//   tgt_duty/step     requested final duty and per-period increment (0 -> 1)
//   hold_periods      (FADE_HOLD_EN only) periods to dwell at target
//   pwm_counter       counter output of the driven pwm instance
//   pwm_enable        pwm enable
//   duty_cycle        pwm duty
//   busy              ramp (or hold) in progress
//   done              one-cycle pulse when the sequence completes
module pwm_fade_ctrl #(
    parameter int CTRVAL = 256,
    parameter int CTRLEN = $clog2(CTRVAL)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              tgt_valid,
    output logic              tgt_ready,
    input  logic [CTRLEN-1:0] tgt_duty,
    input  logic [CTRLEN-1:0] tgt_step,
`ifdef FADE_HOLD_EN
    input  logic [7:0]        hold_periods,
`endif
    input  logic [CTRLEN-1:0] pwm_counter,
    output logic              pwm_enable,
    output logic [CTRLEN-1:0] duty_cycle,
    output logic              busy,
    output logic              done
);

`ifdef FADE_HOLD_EN
    typedef enum logic [1:0] {IDLE = 2'd0, RAMP = 2'd1, HOLD = 2'd2} state_t;
    logic [7:0] hold_cnt, hold_cnt_n;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RAMP = 2'd1} state_t;
`endif

    state_t            state, state_n;
    logic [CTRLEN-1:0] tgt_r, tgt_n;
    logic [CTRLEN-1:0] step_r, step_n;
    logic [CTRLEN-1:0] duty_n;
    logic [CTRLEN-1:0] ramp_duty;
    logic [CTRLEN:0]   up_sum, dn_diff;
    logic              done_n;
    logic              bnd;

    // Last count of an enabled period: a duty written here takes effect
    // from count 0 of the next period.
    assign bnd       = pwm_enable && (pwm_counter == CTRLEN'(CTRVAL - 1));
    assign tgt_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // One step toward the target, computed one bit wider so the sum cannot
    // wrap and the difference exposes underflow in its top bit. Both
    // directions clamp at the target.
    always_comb begin
        up_sum  = {1'b0, duty_cycle} + {1'b0, step_r};
        dn_diff = {1'b0, duty_cycle} - {1'b0, step_r};
        if (duty_cycle < tgt_r)
            ramp_duty = (up_sum >= {1'b0, tgt_r}) ? tgt_r : up_sum[CTRLEN-1:0];
        else
            ramp_duty = (dn_diff[CTRLEN] || (dn_diff[CTRLEN-1:0] <= tgt_r))
                        ? tgt_r : dn_diff[CTRLEN-1:0];
    end

    always_comb begin
        state_n = state;
        duty_n  = duty_cycle;
        tgt_n   = tgt_r;
        step_n  = step_r;
        done_n  = 1'b0;
`ifdef FADE_HOLD_EN
        hold_cnt_n = hold_cnt;
`endif
        case (state)
            IDLE: begin
                if (tgt_valid) begin
                    tgt_n  = tgt_duty;
                    step_n = (tgt_step == '0) ? CTRLEN'(1) : tgt_step;
`ifdef FADE_HOLD_EN
                    hold_cnt_n = hold_periods;
`endif
                    if (tgt_duty != duty_cycle) begin
                        state_n = RAMP;
`ifdef FADE_HOLD_EN
                    end else if (hold_periods != 8'd0) begin
                        state_n = HOLD;
`endif
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            RAMP: begin
                if (bnd) begin
                    duty_n = ramp_duty;
                    if (ramp_duty == tgt_r) begin
`ifdef FADE_HOLD_EN
                        if (hold_cnt != 8'd0) begin
                            state_n = HOLD;
                        end else begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end
`else
                        state_n = IDLE;
                        done_n  = 1'b1;
`endif
                    end
                end
            end
`ifdef FADE_HOLD_EN
            HOLD: begin
                if (bnd) begin
                    hold_cnt_n = hold_cnt - 8'd1;
                    if (hold_cnt == 8'd1) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            duty_cycle <= '0;
            tgt_r      <= '0;
            step_r     <= '0;
            done       <= 1'b0;
            pwm_enable <= 1'b0;
`ifdef FADE_HOLD_EN
            hold_cnt   <= 8'd0;
`endif
        end else begin
            state      <= state_n;
            duty_cycle <= duty_n;
            tgt_r      <= tgt_n;
            step_r     <= step_n;
            done       <= done_n;
            pwm_enable <= run;
`ifdef FADE_HOLD_EN
            hold_cnt   <= hold_cnt_n;
`endif
        end
    end

endmodule
